// File: rtl/pipelined_add_sub.sv
// Pipelined adder/subtractor. The carry chain is cut into STAGES equal chunks, one chunk per stage,
// behind a valid/ready handshake whose ready chain lets bubbles collapse.
module pipelined_add_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] IN1,
    input  logic [WIDTH-1:0] IN2,
    input  logic             Sub,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OUT,
    output logic             Carry,
    output logic             Overflow,
    output logic             Zero
);
    localparam int CW = WIDTH / STAGES;

    logic [STAGES-1:0] v_vec;
    logic [STAGES:0]   rdy;
    logic              c_s [STAGES];
    logic [WIDTH-1:0]  a_s [STAGES];
    logic [WIDTH-1:0]  b_s [STAGES];
    logic [WIDTH-1:0]  r_s [STAGES];
    logic              ovf_q;
    logic              zero_q;

    // A stage may load whenever it is empty or its successor is loading this cycle.
    always_comb begin
        rdy = '0;
        rdy[STAGES] = OutReady;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !v_vec[k] || rdy[k+1];
        end
    end

    assign InReady = rdy[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             v_in;
        logic             c_in;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] r_in;
        logic [WIDTH-1:0] r_next;
        logic [CW:0]      chunk;
        logic             v_q;
        logic             c_q;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] r_q;

        if (k == 0) begin : g_first
            // B is inverted once on entry, so Sub doubles as the carry into chunk 0.
            assign v_in = InValid;
            assign c_in = Sub;
            assign a_in = IN1;
            assign b_in = IN2 ^ {WIDTH{Sub}};
            assign r_in = '0;
        end else begin : g_next
            assign v_in = v_vec[k-1];
            assign c_in = c_s[k-1];
            assign a_in = a_s[k-1];
            assign b_in = b_s[k-1];
            assign r_in = r_s[k-1];
        end

        assign chunk = {1'b0, a_in[k*CW +: CW]} + {1'b0, b_in[k*CW +: CW]} + {{CW{1'b0}}, c_in};

        always_comb begin
            r_next = r_in;
            r_next[k*CW +: CW] = chunk[CW-1:0];
        end

        always_ff @(posedge Clk) begin
            if (Rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                a_q <= '0;
                b_q <= '0;
                r_q <= '0;
            end else if (rdy[k]) begin
                v_q <= v_in;
                c_q <= chunk[CW];
                a_q <= a_in;
                b_q <= b_in;
                r_q <= r_next;
            end
        end

        assign v_vec[k] = v_q;
        assign c_s[k]   = c_q;
        assign a_s[k]   = a_q;
        assign b_s[k]   = b_q;
        assign r_s[k]   = r_q;

        if (k == STAGES - 1) begin : g_flags
            // Flags are registered alongside the final chunk so every output leaves a flop.
            always_ff @(posedge Clk) begin
                if (Rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (rdy[k]) begin
                    ovf_q  <= (a_in[WIDTH-1] == b_in[WIDTH-1]) && (r_next[WIDTH-1] != a_in[WIDTH-1]);
                    zero_q <= (r_next == '0);
                end
            end
        end
    end

    assign OutValid = v_vec[STAGES-1];
    assign OUT      = r_s[STAGES-1];
    assign Carry    = c_s[STAGES-1];
    assign Overflow = ovf_q;
    assign Zero     = zero_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench for pipelined_add_sub: directed vectors, backpressured streaming,
// mid-stall reset, and a random sweep over STAGES=1/4 and WIDTH=16 against an arithmetic model.
module tb_pipelined_add_sub;
    typedef struct {
        logic [31:0] out;
        logic        carry;
        logic        ovf;
        logic        zero;
        int          t;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        InValid;
    logic        InReady;
    logic [31:0] IN1;
    logic [31:0] IN2;
    logic        Sub;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] OUT;
    logic        Carry;
    logic        Overflow;
    logic        Zero;

    logic        sw_valid;
    logic        sw_sub;
    logic        sw_ordy;
    logic [31:0] sw_a;
    logic [31:0] sw_b;
    logic [2:0]  s_ir;
    logic [2:0]  s_ov;
    logic [2:0]  s_c;
    logic [2:0]  s_of;
    logic [2:0]  s_z;
    logic [31:0] out_s1;
    logic [31:0] out_s4;
    logic [15:0] out_w16;
    logic [31:0] s_out [3];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int issued = 0;
    int got = 0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_out = '0;
    logic [31:0] last_out;
    logic [2:0]  last_flags;
    exp_t mq[$];
    exp_t sq[3][$];
    int sw_st[3] = '{1, 4, 2};
    int sw_w[3]  = '{32, 32, 16};

    always #5 Clk = ~Clk;

    pipelined_add_sub #(.WIDTH(32), .STAGES(2)) dut (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady), .IN1(IN1), .IN2(IN2),
        .Sub(Sub), .OutValid(OutValid), .OutReady(OutReady), .OUT(OUT), .Carry(Carry),
        .Overflow(Overflow), .Zero(Zero));

    pipelined_add_sub #(.WIDTH(32), .STAGES(1)) dut_s1 (
        .Clk(Clk), .Rst(Rst), .InValid(sw_valid), .InReady(s_ir[0]), .IN1(sw_a), .IN2(sw_b),
        .Sub(sw_sub), .OutValid(s_ov[0]), .OutReady(sw_ordy), .OUT(out_s1), .Carry(s_c[0]),
        .Overflow(s_of[0]), .Zero(s_z[0]));

    pipelined_add_sub #(.WIDTH(32), .STAGES(4)) dut_s4 (
        .Clk(Clk), .Rst(Rst), .InValid(sw_valid), .InReady(s_ir[1]), .IN1(sw_a), .IN2(sw_b),
        .Sub(sw_sub), .OutValid(s_ov[1]), .OutReady(sw_ordy), .OUT(out_s4), .Carry(s_c[1]),
        .Overflow(s_of[1]), .Zero(s_z[1]));

    pipelined_add_sub #(.WIDTH(16), .STAGES(2)) dut_w16 (
        .Clk(Clk), .Rst(Rst), .InValid(sw_valid), .InReady(s_ir[2]), .IN1(sw_a[15:0]),
        .IN2(sw_b[15:0]), .Sub(sw_sub), .OutValid(s_ov[2]), .OutReady(sw_ordy), .OUT(out_w16),
        .Carry(s_c[2]), .Overflow(s_of[2]), .Zero(s_z[2]));

    assign s_out[0] = out_s1;
    assign s_out[1] = out_s4;
    assign s_out[2] = {16'h0, out_w16};

    // Reference: true unsigned and signed arithmetic on w-bit operands.
    function automatic exp_t refModel(input int w, input logic [31:0] a, input logic [31:0] b,
                                      input logic sub);
        exp_t r;
        longint mask, half, ua, ub, full, sa, sb, ss;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua = longint'({32'h0, a}) & mask;
        ub = longint'({32'h0, b}) & mask;
        full = sub ? (ua + ((~ub) & mask) + 1) : (ua + ub);
        sa = (ua >= half) ? ua - (longint'(1) << w) : ua;
        sb = (ub >= half) ? ub - (longint'(1) << w) : ub;
        ss = sub ? (sa - sb) : (sa + sb);
        r.out   = 32'(full & mask);
        r.carry = full[w];
        r.ovf   = (ss >= half) || (ss < -half);
        r.zero  = ((full & mask) == 0);
        r.t     = 0;
        return r;
    endfunction

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 11))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'h0000_8000;
            5: return 32'h0000_7FFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // One isolated operation with OutReady high: result must appear exactly two cycles later.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sub);
        exp_t e;
        e = refModel(32, a, b, sub);
        InValid = 1'b1; IN1 = a; IN2 = b; Sub = sub; OutReady = 1'b1;
        @(negedge Clk);
        checkOutput("dir_idle", OutValid, 1'b0);
        checkOutput("dir_in_ready", InReady, 1'b1);
        @(posedge Clk); #1;
        InValid = 1'b0; IN1 = $urandom(); IN2 = $urandom(); Sub = 1'($urandom());
        @(negedge Clk);
        checkOutput("dir_early", OutValid, 1'b0);
        @(posedge Clk); #1;
        @(negedge Clk);
        checkOutput("dir_latency", OutValid, 1'b1);
        checkOutput("dir_result", {OUT, Carry, Overflow, Zero}, {e.out, e.carry, e.ovf, e.zero});
        last_out = OUT;
        last_flags = {Carry, Overflow, Zero};
        @(posedge Clk); #1;
    endtask

    // One handshake cycle on the STAGES=2 DUT, scored against the in-flight queue.
    task automatic runCycle(input logic iv, input logic [31:0] a, input logic [31:0] b,
                            input logic sub, input logic ordy);
        exp_t e;
        logic in_x;
        logic out_x;
        InValid = iv; IN1 = a; IN2 = b; Sub = sub; OutReady = ordy;
        @(negedge Clk);
        checkOutput("in_ready", InReady, (mq.size() < 2) || OutReady);
        if (prev_stall) begin
            checkOutput("hold_valid", OutValid, 1'b1);
            checkOutput("hold_out", OUT, prev_out);
        end
        if (mq.size() == 0) checkOutput("no_spurious", OutValid, 1'b0);
        out_x = OutValid && OutReady;
        in_x = InValid && InReady;
        if (out_x && mq.size() != 0) begin
            e = mq.pop_front();
            checkOutput("result", {OUT, Carry, Overflow, Zero}, {e.out, e.carry, e.ovf, e.zero});
            checkOutput("latency_min", (cyc - e.t) >= 2, 1'b1);
            got++;
        end
        prev_stall = OutValid && !OutReady;
        prev_out = OUT;
        if (in_x) begin
            e = refModel(32, a, b, sub);
            e.t = cyc;
            mq.push_back(e);
            issued++;
        end
        @(posedge Clk); #1;
        cyc++;
    endtask

    initial begin
        exp_t e;
        Rst = 1'b1; InValid = 1'b0; IN1 = '0; IN2 = '0; Sub = 1'b0; OutReady = 1'b0;
        sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_sub = 1'b0; sw_ordy = 1'b1;

        repeat (2) @(posedge Clk);
        #1;
        @(negedge Clk);
        checkOutput("rst_valid", OutValid, 1'b0);
        checkOutput("rst_out", OUT, 32'h0);
        checkOutput("rst_flags", {Carry, Overflow, Zero}, 3'b000);
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(negedge Clk);
        checkOutput("rst_in_ready", InReady, 1'b1);
        @(posedge Clk); #1;

        applyStimulus(32'h0000_0004, 32'h0040_0000, 1'b0);
        checkOutput("tp_add_out", last_out, 32'h0040_0004);
        checkOutput("tp_add_flags", last_flags, 3'b000);
        applyStimulus(32'h0000_FFFF, 32'h0000_0001, 1'b0);
        checkOutput("tp_chunk_out", last_out, 32'h0001_0000);
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        checkOutput("tp_wrap_out", last_out, 32'h0);
        checkOutput("tp_wrap_flags", last_flags, 3'b101);
        applyStimulus(32'd5, 32'd7, 1'b1);
        checkOutput("tp_sub_neg_out", last_out, 32'hFFFF_FFFE);
        checkOutput("tp_sub_neg_flags", last_flags, 3'b000);
        applyStimulus(32'd7, 32'd5, 1'b1);
        checkOutput("tp_sub_pos_out", last_out, 32'h2);
        checkOutput("tp_sub_pos_flags", last_flags, 3'b100);
        applyStimulus(32'h7FFF_FFFF, 32'h1, 1'b0);
        checkOutput("tp_ovf_add_flags", last_flags, 3'b010);
        applyStimulus(32'h8000_0000, 32'h1, 1'b1);
        checkOutput("tp_ovf_sub_out", last_out, 32'h7FFF_FFFF);
        checkOutput("tp_ovf_sub_flags", last_flags, 3'b110);

        issued = 0; got = 0; prev_stall = 1'b0;
        for (int c = 0; c < 80 && got < 8; c++) begin
            runCycle(issued < 8, 32'(issued), 32'h100, 1'b0, (c % 4 == 0) || (c % 4 == 3));
        end
        checkOutput("strm_count", 64'(got), 64'd8);
        checkOutput("strm_empty", 64'(mq.size()), 64'd0);

        for (int c = 0; c < 1500; c++) begin
            runCycle($urandom_range(0, 3) != 0, rnd(), rnd(), 1'($urandom()), $urandom_range(0, 2) != 0);
        end
        for (int c = 0; c < 20 && mq.size() != 0; c++) begin
            runCycle(1'b0, '0, '0, 1'b0, 1'b1);
        end
        checkOutput("rand_drain", 64'(mq.size()), 64'd0);

        OutReady = 1'b0; InValid = 1'b1;
        repeat (3) begin
            IN1 = rnd(); IN2 = rnd(); Sub = 1'($urandom());
            @(posedge Clk); #1;
        end
        @(negedge Clk);
        checkOutput("fill_in_ready", InReady, 1'b0);
        checkOutput("fill_valid", OutValid, 1'b1);
        @(posedge Clk); #1;
        Rst = 1'b1; InValid = 1'b0;
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(negedge Clk);
        checkOutput("midrst_valid", OutValid, 1'b0);
        checkOutput("midrst_out", OUT, 32'h0);
        checkOutput("midrst_flags", {Carry, Overflow, Zero}, 3'b000);
        checkOutput("midrst_in_ready", InReady, 1'b1);
        OutReady = 1'b1;
        repeat (4) begin
            @(posedge Clk); #1;
            @(negedge Clk);
            checkOutput("midrst_no_stale", OutValid, 1'b0);
        end
        @(posedge Clk); #1;
        prev_stall = 1'b0;

        for (int c = 0; c < 10006; c++) begin
            sw_valid = (c < 10000) && ($urandom_range(0, 3) != 0);
            sw_a = rnd(); sw_b = rnd(); sw_sub = 1'($urandom());
            @(negedge Clk);
            for (int d = 0; d < 3; d++) begin
                checkOutput($sformatf("sw%0d_in_ready", d), s_ir[d], 1'b1);
                if (sq[d].size() != 0 && (cyc - sq[d][0].t) == sw_st[d]) begin
                    e = sq[d].pop_front();
                    checkOutput($sformatf("sw%0d_valid", d), s_ov[d], 1'b1);
                    checkOutput($sformatf("sw%0d_result", d), {s_out[d], s_c[d], s_of[d], s_z[d]},
                                {e.out, e.carry, e.ovf, e.zero});
                end else begin
                    checkOutput($sformatf("sw%0d_idle", d), s_ov[d], 1'b0);
                end
                if (sw_valid && s_ir[d]) begin
                    e = refModel(sw_w[d], sw_a, sw_b, sw_sub);
                    e.t = cyc;
                    sq[d].push_back(e);
                end
            end
            @(posedge Clk); #1;
            cyc++;
        end
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("sw%0d_drain", d), 64'(sq[d].size()), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
